aer_tx_fifo: RTL

Parametrised, buffered AER transmitter for the accelerator's input side. Events (pixel/neuron addresses) from the sorter are accepted through a valid/ready port and queued in a FIFO. They are then sent off-chip, one at a time, over a 4-phase REQ/ACK AER link with a configurable ACK synchroniser. The sorter can keep producing while the link is stalled. An optional watchdog recovers from a non-responding receiver.

---
 rtl/aer_tx_fifo_if.sv | 28 ++
 rtl/aer_tx_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aer_tx_fifo_if.sv
// aer_tx_fifo_if: sorter-side event port and off-chip AER link of aer_tx_fifo.
// "slave" is the transmitter's view, "master" is the environment's view.
interface aer_tx_fifo_if #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] EV_ADDR;
  logic              EV_VALID;
  logic              EV_READY;
  logic [CNT_W-1:0]  FIFO_COUNT;
  logic              BUSY;
  logic [ADDR_W-1:0] AERIN_ADDR;
  logic              AERIN_REQ;
  logic              AERIN_ACK;
  logic              TIMEOUT_ERR;

  modport slave (
    input  EV_ADDR, EV_VALID, AERIN_ACK,
    output EV_READY, FIFO_COUNT, BUSY, AERIN_ADDR, AERIN_REQ, TIMEOUT_ERR
  );

  modport master (
    output EV_ADDR, EV_VALID, AERIN_ACK,
    input  EV_READY, FIFO_COUNT, BUSY, AERIN_ADDR, AERIN_REQ, TIMEOUT_ERR
  );
endinterface

// File: rtl/aer_tx_fifo.sv
// aer_tx_fifo: buffered 4-phase AER transmitter. Events enter a FIFO through a
// valid/ready port and leave one at a time over REQ/ACK with a synchronised ACK.
// Optional watchdog on REQ_HI is enabled by defining AER_TX_TIMEOUT_EN.
module aer_tx_fifo #(
  parameter int ADDR_W         = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  aer_tx_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("aer_tx_fifo: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [ADDR_W-1:0]   mem_q [FIFO_DEPTH];

  logic ack_s;
  logic fifo_empty;
  logic ev_ready;
  logic push;
  logic pop;

`ifdef AER_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             err_q, err_d;

  assign tmo_inc         = tmo_q + TMO_W'(1);
  assign bus.TIMEOUT_ERR = err_q;
`else
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

  assign ack_s      = ack_sync_q[SYNC_STAGES-1];
  assign fifo_empty = (count_q == '0);

  assign bus.EV_READY   = ev_ready;
  assign bus.FIFO_COUNT = count_q;
  assign bus.BUSY       = !fifo_empty || (state_q != IDLE);
  assign bus.AERIN_ADDR = addr_q;
  assign bus.AERIN_REQ  = req_q;

  // Ready from registered occupancy only; a same-edge pop never frees a full FIFO.
  always_comb begin
    ev_ready = !RST && (count_q < DEPTH_C);
    push     = bus.EV_VALID && ev_ready;
  end

  // ACK synchroniser shift and FIFO pointer/occupancy bookkeeping.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.AERIN_ACK};
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Handshake FSM: pop and raise REQ only while the synchronised ACK is low.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pop     = 1'b0;
`ifdef AER_TX_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          addr_d  = mem_q[rd_ptr_q];
          state_d = REQ_HI;
`ifdef AER_TX_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LO;
        end
`ifdef AER_TX_TIMEOUT_EN
        // Limit reached: abandon the in-flight event, then behave as if acked.
        else if (tmo_inc == TMO_LIMIT) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ACK_LO;
        end else begin
          tmo_d   = tmo_inc;
        end
`endif
      end
      ACK_LO: begin
        if (!ack_s) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            req_d   = 1'b1;
            addr_d  = mem_q[rd_ptr_q];
            state_d = REQ_HI;
`ifdef AER_TX_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Event storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.EV_ADDR;
    end
  end

  // State, outputs, pointers and synchroniser; reset discards all queued events.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_sync_q <= '0;
`ifdef AER_TX_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_sync_q <= ack_sync_d;
`ifdef AER_TX_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule
